// File: rtl/wifi_phy_pkg.sv
// Shared WiFi PHY receive-chain definitions: puncture rate codes, pattern
// periods and erasure masks, FSM state encoding and the SIGNAL header length.
package wifi_phy_pkg;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_e;

    localparam int HDR_BITS_DEF = 48;

    localparam logic [2:0] PERIOD_1_2 = 3'd1;
    localparam logic [2:0] PERIOD_2_3 = 3'd4;
    localparam logic [2:0] PERIOD_3_4 = 3'd6;

    // Bit p set means pattern phase p is an inserted erasure slot.
    localparam logic [7:0] MASK_1_2 = 8'b0000_0000;
    localparam logic [7:0] MASK_2_3 = 8'b0000_1000;
    localparam logic [7:0] MASK_3_4 = 8'b0001_1000;

    function automatic logic [2:0] rate_period(input rate_e r);
        case (r)
            RATE_2_3: return PERIOD_2_3;
            RATE_3_4: return PERIOD_3_4;
            default:  return PERIOD_1_2;
        endcase
    endfunction

    function automatic logic [7:0] rate_mask(input rate_e r);
        case (r)
            RATE_2_3: return MASK_2_3;
            RATE_3_4: return MASK_3_4;
            default:  return MASK_1_2;
        endcase
    endfunction

endpackage

// File: rtl/depuncture_sched_wifi_if.sv
// Frame buffer RAM port bundle: the scheduler is master, the bit RAM is slave.
interface depuncture_sched_wifi_if #(
    parameter int ADDR_W = 12
) ();
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic              data_write;
    logic              re;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;

    modport master (output we, wr_addr, data_write, re, rd_addr, input rd_data);
    modport slave  (input we, wr_addr, data_write, re, rd_addr, output rd_data);
endinterface

// File: rtl/depuncture_pattern_wifi.sv
// Puncture pattern tracker: phase counter over the rate's period, flags
// whether the current phase is an erasure slot.
module depuncture_pattern_wifi
    import wifi_phy_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  rate_e rate_i,
    input  logic  advance_i,
    input  logic  clear_i,
    output logic  erase_o
);

    logic [2:0] phase_q;
    logic [2:0] phase_d;
    logic [2:0] period;
    logic [7:0] mask;

    always_comb begin
        period  = rate_period(rate_i);
        mask    = rate_mask(rate_i);
        phase_d = phase_q;
        if (clear_i) begin
            phase_d = 3'd0;
        end else if (advance_i) begin
            phase_d = (phase_q == period - 3'd1) ? 3'd0 : phase_q + 3'd1;
        end
        erase_o = mask[phase_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= 3'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/depuncture_sched_wifi.sv
// Multi-rate depuncture scheduler: buffers one frame of coded bits, then
// replays it with zero erasure slots inserted per the 802.11a puncture pattern.
module depuncture_sched_wifi
    import wifi_phy_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int HDR_BITS = HDR_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic                   data_in,
    input  logic [1:0]             rate_sel,
    depuncture_sched_wifi_if.master buf_if,
    output logic                   valid_out,
    output logic                   data_out,
    output logic                   erase_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [ADDR_W:0] MAX_L = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] HDR_L = (ADDR_W + 1)'(HDR_BITS);
    localparam logic [ADDR_W:0] ONE_L = (ADDR_W + 1)'(1);

    state_e            state_q;
    rate_e             rate_q;
    logic [ADDR_W:0]   cnt_q, len_q, rdPtr_q, lenNow;
    logic [ADDR_W-1:0] wrAddr_q, rdAddr_q;
    logic we_q, dataWrite_q, re_q, erSlot_q, validOut_q, eraseOut_q;
    logic done_q, err_q, busy_q, ovf_q, vinPrev_q;
    logic vinRise, inHdr, issueActive, issueErase, issueLast;
    logic patAdvance, patClear, patErase;

    depuncture_pattern_wifi u_pattern (
        .clk       (clk),
        .reset     (reset),
        .rate_i    (rate_q),
        .advance_i (patAdvance),
        .clear_i   (patClear),
        .erase_o   (patErase)
    );

    // Slot issue happens in READ and also on the WRITE cycle where the frame
    // ends, so the first read leaves the cycle right after valid_in drops.
    always_comb begin
        vinRise     = valid_in && !vinPrev_q;
        lenNow      = (state_q == ST_WRITE) ? cnt_q : len_q;
        inHdr       = rdPtr_q < HDR_L;
        issueActive = (state_q == ST_READ) || ((state_q == ST_WRITE) && !valid_in);
        issueErase  = !inHdr && patErase;
        issueLast   = !issueErase && (rdPtr_q == lenNow - ONE_L);
        patAdvance  = issueActive && !inHdr;
        patClear    = (state_q == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rate_q      <= RATE_1_2;
            cnt_q       <= '0;
            len_q       <= '0;
            rdPtr_q     <= '0;
            wrAddr_q    <= '0;
            rdAddr_q    <= '0;
            we_q        <= 1'b0;
            dataWrite_q <= 1'b0;
            re_q        <= 1'b0;
            erSlot_q    <= 1'b0;
            validOut_q  <= 1'b0;
            eraseOut_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            vinPrev_q   <= 1'b0;
        end else begin
            vinPrev_q  <= valid_in;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            erSlot_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            validOut_q <= re_q | erSlot_q;
            eraseOut_q <= erSlot_q;
            case (state_q)
                ST_IDLE: begin
                    if (vinRise) begin
                        rate_q      <= (rate_sel == 2'b11) ? RATE_1_2 : rate_e'(rate_sel);
                        err_q       <= (rate_sel == 2'b11);
                        we_q        <= 1'b1;
                        wrAddr_q    <= '0;
                        dataWrite_q <= data_in;
                        cnt_q       <= ONE_L;
                        rdPtr_q     <= '0;
                        ovf_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (valid_in) begin
                        if (cnt_q != MAX_L) begin
                            we_q        <= 1'b1;
                            wrAddr_q    <= cnt_q[ADDR_W-1:0];
                            dataWrite_q <= data_in;
                            cnt_q       <= cnt_q + ONE_L;
                        end else if (!ovf_q) begin
                            err_q <= 1'b1;
                            ovf_q <= 1'b1;
                        end
                    end else begin
                        len_q   <= cnt_q;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    err_q <= vinRise;
                end
                ST_DONE: begin
                    err_q   <= vinRise;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            // Placed after the case so the last read can override the READ entry.
            if (issueActive) begin
                if (issueErase) begin
                    erSlot_q <= 1'b1;
                end else begin
                    re_q     <= 1'b1;
                    rdAddr_q <= rdPtr_q[ADDR_W-1:0];
                    rdPtr_q  <= rdPtr_q + ONE_L;
                    if (issueLast) begin
                        state_q <= ST_DONE;
                    end
                end
            end
        end
    end

    assign buf_if.we         = we_q;
    assign buf_if.wr_addr    = wrAddr_q;
    assign buf_if.data_write = dataWrite_q;
    assign buf_if.re         = re_q;
    assign buf_if.rd_addr    = rdAddr_q;
    assign valid_out         = validOut_q;
    assign erase_out         = eraseOut_q;
    assign data_out          = validOut_q & ~eraseOut_q & buf_if.rd_data;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;

endmodule
